rvfi_trace_monitor: RTL and testbench
=====================================

Name: rvfi_trace_monitor

Overview:
- Passive consumer of the RVFI retirement stream that dtcore32 produces, for formal and simulation benches.
- Each retirement is checked against a running model:
  - order continuity
  - PC continuity
  - x0 discipline
  - operand consistency against a shadow register file
  - memory mask legality
  - post-halt silence
- Check failures are reported as registered sticky error flags, plus the order number of the first failing retirement.

Parameters:
- RESET_PC, 32'h0000_0000, PC the first retirement's pc_rdata must equal.
- CHECK_REGS, 1, 1 enables the shadow register file and the RS1/RS2 checks; 0 forces flag bits 3/4 to 0.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- rvfi_valid  in  1  retirement strobe.
- rvfi_order  in  64  retirement index.
- rvfi_insn  in  32  retired instruction word (carried for debug only).
- rvfi_trap  in  1  retirement trapped.
- rvfi_halt  in  1  core halted after this retirement.
- rvfi_rs1_addr, rvfi_rs2_addr  in  5 each  source register indices.
- rvfi_rs1_rdata, rvfi_rs2_rdata  in  32 each  source operand values.
- rvfi_rd_addr  in  5  destination register index.
- rvfi_rd_wdata  in  32  destination write value.
- rvfi_pc_rdata, rvfi_pc_wdata  in  32 each  PC of this instruction / next PC.
- rvfi_mem_addr  in  32  memory access address.
- rvfi_mem_rmask, rvfi_mem_wmask  in  4 each  byte read / write masks.
- mon_err_o  out  1  OR of all flag bits.
- mon_err_flags_o  out  8  sticky per-check flags (bit map below).
- mon_first_err_order_o  out  64  rvfi_order of the first failing retirement.
- mon_retired_o  out  64  count of accepted retirements.
- mon_halted_o  out  1  halt has been observed.

Behaviour:
- Reset (async, rst_i=1): all outputs 0. exp_order=0, exp_pc=RESET_PC, shadow valid bits cleared, halted=0.
- Checks are evaluated only in cycles where rvfi_valid=1; cycles with rvfi_valid=0 change no state.
- Results are registered: flags, counters and model state update on the clock edge that samples rvfi_valid=1. Outputs are therefore visible one cycle later.
- Flag bit map:
  - [0] ORDER: rvfi_order != exp_order.
  - [1] PC: rvfi_pc_rdata != exp_pc.
  - [2] X0: rvfi_rd_addr==0 and rvfi_rd_wdata!=0.
  - [3] RS1: rs1_addr==0 with rs1_rdata!=0, or shadow_valid[rs1_addr] with shadow[rs1_addr] != rs1_rdata.
  - [4] RS2: same rule as RS1, applied to rs2.
  - [5] MASK: rmask!=0 and wmask!=0 in the same retirement (illegal for RV32I, which has no AMOs).
  - [6] AFTER_HALT: rvfi_valid=1 while halted=1.
  - [7] PC_ALIGN: rvfi_trap=0 and rvfi_pc_wdata[1:0]!=0.
- Flags are sticky: each bit ORs in new failures and is cleared only by reset.
- mon_first_err_order_o loads rvfi_order on the first retirement that raises any flag while mon_err_o=0. It holds that value afterwards, even when later retirements also fail.
- Model update on every valid retirement, trapped or not:
  - exp_order <= exp_order+1. The monitor does not resync to rvfi_order, so one skipped order produces ORDER failures on all following retirements.
  - exp_pc <= rvfi_pc_wdata.
  - mon_retired_o increments (64-bit, wraps modulo 2^64).
  - halted sets if rvfi_halt=1.
- Shadow register file (CHECK_REGS=1): 31 entries of 32 bits (x1..x31) plus per-entry valid bits.
  - Written when valid, rvfi_trap=0 and rd_addr!=0: shadow[rd] <= rd_wdata, valid[rd] <= 1.
  - Trapped retirements do not write the shadow.
  - Same-retirement read-after-write: rs1/rs2 are compared against the pre-update shadow contents (old value). Example: add x5,x5,x5 compares rs1 against the old x5.
  - An entry with valid=0 is never checked; its first write establishes the value.
- Halt: retirements after halt still update counters and model state, but raise AFTER_HALT.
- Reset mid-stream: async clear of everything. The first retirement after reset must carry order 0 and pc_rdata=RESET_PC.
- The block is purely passive: it has no back-pressure and no outputs toward the core.

Test Plan:
- Three valid retirements: orders 0,1,2; pcs 0→4→8 (pc_wdata=4,8,12). Each writes x1 with 0x11 → flags stay 0x00, mon_retired_o=3, mon_err_o=0.
- Orders 0,1,3 with continuous PCs → bit0 set one cycle after order 3 is sampled. mon_first_err_order_o=3. A following order-4 retirement keeps bit0 set; first_err stays 3.
- Retire "x7<=0xDEAD" (order 0), then a retirement reading rs1=x7 with rs1_rdata=0xBEEF → flags=0x08. Repeat with rs1_rdata=0xDEAD → flags stay 0x00.
- Retirement with rd_addr=0, rd_wdata=5, rmask=4'hF, wmask=4'h1 → flags=0x24 (X0 and MASK).
- Retirement with rvfi_halt=1, then another valid retirement → mon_halted_o=1, then flags bit6 set. Assert rst_i asynchronously mid-cycle → all outputs 0 immediately, before the next clock edge.
- Trapped retirement with pc_wdata=0x102 and rd_addr=3 → no PC_ALIGN flag, and x3 shadow stays invalid. Next retirement must have pc_rdata=0x102, otherwise bit1 sets.

Source files
------------

// File: rtl/rvfi_trace_monitor.sv
// Passive RVFI retirement-stream checker: order/PC continuity, x0 and
// operand consistency, mask legality and post-halt silence, as sticky flags.
module rvfi_trace_monitor #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          CHECK_REGS = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rvfi_valid,
   input  logic [63:0] rvfi_order,
   input  logic [31:0] rvfi_insn,
   input  logic        rvfi_trap,
   input  logic        rvfi_halt,
   input  logic [4:0]  rvfi_rs1_addr,
   input  logic [4:0]  rvfi_rs2_addr,
   input  logic [31:0] rvfi_rs1_rdata,
   input  logic [31:0] rvfi_rs2_rdata,
   input  logic [4:0]  rvfi_rd_addr,
   input  logic [31:0] rvfi_rd_wdata,
   input  logic [31:0] rvfi_pc_rdata,
   input  logic [31:0] rvfi_pc_wdata,
   input  logic [31:0] rvfi_mem_addr,
   input  logic [3:0]  rvfi_mem_rmask,
   input  logic [3:0]  rvfi_mem_wmask,
   output logic        mon_err_o,
   output logic [7:0]  mon_err_flags_o,
   output logic [63:0] mon_first_err_order_o,
   output logic [63:0] mon_retired_o,
   output logic        mon_halted_o
);

   logic [63:0] exp_order_q, exp_order_d;
   logic [31:0] exp_pc_q, exp_pc_d;
   logic [63:0] retired_q, retired_d;
   logic [63:0] first_q, first_d;
   logic [7:0]  flags_q, flags_d;
   logic        halted_q, halted_d;
   logic [31:0] svld_q, svld_d;
   logic [31:0] shadow_q [32];

   logic [7:0]  new_flags;
   logic        rs1_bad, rs2_bad;
   logic        shadow_we;

   // Debug-only fields; kept on the port list for trace completeness.
   logic unused_ok;
   assign unused_ok = ^{rvfi_insn, rvfi_mem_addr};

   // Operands compare against pre-update shadow contents.
   always_comb begin
      rs1_bad = 1'b0;
      rs2_bad = 1'b0;
      if (CHECK_REGS != 0) begin
         if (rvfi_rs1_addr == 5'd0)
            rs1_bad = rvfi_rs1_rdata != 32'd0;
         else
            rs1_bad = svld_q[rvfi_rs1_addr] &&
                      (shadow_q[rvfi_rs1_addr] != rvfi_rs1_rdata);
         if (rvfi_rs2_addr == 5'd0)
            rs2_bad = rvfi_rs2_rdata != 32'd0;
         else
            rs2_bad = svld_q[rvfi_rs2_addr] &&
                      (shadow_q[rvfi_rs2_addr] != rvfi_rs2_rdata);
      end
   end

   always_comb begin
      new_flags    = 8'h00;
      new_flags[0] = rvfi_order != exp_order_q;
      new_flags[1] = rvfi_pc_rdata != exp_pc_q;
      new_flags[2] = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
      new_flags[3] = rs1_bad;
      new_flags[4] = rs2_bad;
      new_flags[5] = (|rvfi_mem_rmask) && (|rvfi_mem_wmask);
      new_flags[6] = halted_q;
      new_flags[7] = !rvfi_trap && (rvfi_pc_wdata[1:0] != 2'b00);
   end

   assign shadow_we = (CHECK_REGS != 0) && rvfi_valid && !rvfi_trap &&
                      (rvfi_rd_addr != 5'd0);

   always_comb begin
      exp_order_d = exp_order_q;
      exp_pc_d    = exp_pc_q;
      retired_d   = retired_q;
      first_d     = first_q;
      flags_d     = flags_q;
      halted_d    = halted_q;
      svld_d      = svld_q;
      if (rvfi_valid) begin
         exp_order_d = exp_order_q + 64'd1;
         exp_pc_d    = rvfi_pc_wdata;
         retired_d   = retired_q + 64'd1;
         flags_d     = flags_q | new_flags;
         halted_d    = halted_q | rvfi_halt;
         if ((flags_q == 8'h00) && (new_flags != 8'h00))
            first_d = rvfi_order;
         if (shadow_we)
            svld_d[rvfi_rd_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         exp_order_q <= 64'd0;
         exp_pc_q    <= RESET_PC;
         retired_q   <= 64'd0;
         first_q     <= 64'd0;
         flags_q     <= 8'h00;
         halted_q    <= 1'b0;
         svld_q      <= 32'd0;
      end else begin
         exp_order_q <= exp_order_d;
         exp_pc_q    <= exp_pc_d;
         retired_q   <= retired_d;
         first_q     <= first_d;
         flags_q     <= flags_d;
         halted_q    <= halted_d;
         svld_q      <= svld_d;
      end
   end

   // Data needs no reset: entries are gated by their valid bits.
   always_ff @(posedge clk_i) begin
      if (shadow_we)
         shadow_q[rvfi_rd_addr] <= rvfi_rd_wdata;
   end

   assign mon_err_o             = |flags_q;
   assign mon_err_flags_o       = flags_q;
   assign mon_first_err_order_o = first_q;
   assign mon_retired_o         = retired_q;
   assign mon_halted_o          = halted_q;

endmodule

// File: tb/tb_rvfi_trace_monitor.sv
// Directed bench for rvfi_trace_monitor: hand-computed retirement
// sequences with immediate assertions at each check point.
module tb_rvfi_trace_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid;
   logic [63:0] order;
   logic [31:0] insn;
   logic        trap, halt;
   logic [4:0]  rs1a, rs2a, rda;
   logic [31:0] rs1d, rs2d, rdw;
   logic [31:0] pcr, pcw, maddr;
   logic [3:0]  rmask, wmask;
   logic        err, halted;
   logic [7:0]  flags;
   logic [63:0] first, retired;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rvfi_trace_monitor dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .rvfi_valid            (valid),
      .rvfi_order            (order),
      .rvfi_insn             (insn),
      .rvfi_trap             (trap),
      .rvfi_halt             (halt),
      .rvfi_rs1_addr         (rs1a),
      .rvfi_rs2_addr         (rs2a),
      .rvfi_rs1_rdata        (rs1d),
      .rvfi_rs2_rdata        (rs2d),
      .rvfi_rd_addr          (rda),
      .rvfi_rd_wdata         (rdw),
      .rvfi_pc_rdata         (pcr),
      .rvfi_pc_wdata         (pcw),
      .rvfi_mem_addr         (maddr),
      .rvfi_mem_rmask        (rmask),
      .rvfi_mem_wmask        (wmask),
      .mon_err_o             (err),
      .mon_err_flags_o       (flags),
      .mon_first_err_order_o (first),
      .mon_retired_o         (retired),
      .mon_halted_o          (halted)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr;
      valid = 0; order = 0; insn = 32'h13; trap = 0; halt = 0;
      rs1a = 0; rs2a = 0; rs1d = 0; rs2d = 0; rda = 0; rdw = 0;
      pcr = 0; pcw = 0; maddr = 0; rmask = 0; wmask = 0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      clr();
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   // Drive one retirement for one posedge; outputs checked at next negedge.
   task automatic fire(input logic [63:0] o, input logic [31:0] pr,
                       input logic [31:0] pw);
      order = o; pcr = pr; pcw = pw; valid = 1;
      @(negedge clk);
      clr();
   endtask

   initial begin
      clr();
      @(negedge clk);
      @(negedge clk);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_flags", {56'd0, flags}, 64'd0);
      chk("rst_first", first, 64'd0);
      chk("rst_retired", retired, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);
      rst = 0;

      // Clean stream
      @(negedge clk);
      rda = 1; rdw = 32'h11; fire(0, 32'h0, 32'h4);
      rda = 1; rdw = 32'h11; fire(1, 32'h4, 32'h8);
      rda = 1; rdw = 32'h11; fire(2, 32'h8, 32'hC);
      chk("clean_flags", {56'd0, flags}, 64'd0);
      chk("clean_retired", retired, 64'd3);
      chk("clean_err", {63'd0, err}, 64'd0);
      order = 64'd99; pcr = 32'h55;
      repeat (3) @(negedge clk);
      clr();
      chk("idle_retired", retired, 64'd3);
      chk("idle_flags", {56'd0, flags}, 64'd0);

      // Order skip
      do_reset();
      fire(0, 32'h0, 32'h4);
      fire(1, 32'h4, 32'h8);
      chk("skip_pre", {56'd0, flags}, 64'd0);
      fire(3, 32'h8, 32'hC);
      chk("skip_flags", {56'd0, flags}, 64'h01);
      chk("skip_first", first, 64'd3);
      chk("skip_err", {63'd0, err}, 64'd1);
      fire(4, 32'hC, 32'h10);
      chk("skip_flags2", {56'd0, flags}, 64'h01);
      chk("skip_first2", first, 64'd3);
      chk("skip_retired", retired, 64'd4);

      // Shadow register mismatch
      do_reset();
      rda = 7; rdw = 32'hDEAD; fire(0, 32'h0, 32'h4);
      rs1a = 7; rs1d = 32'hBEEF; fire(1, 32'h4, 32'h8);
      chk("rs1_bad", {56'd0, flags}, 64'h08);
      chk("rs1_first", first, 64'd1);

      // Shadow match, RAW uses old value, then rs2 mismatch
      do_reset();
      rda = 7; rdw = 32'hDEAD; fire(0, 32'h0, 32'h4);
      rs1a = 7; rs1d = 32'hDEAD; fire(1, 32'h4, 32'h8);
      chk("rs1_ok", {56'd0, flags}, 64'h00);
      rs1a = 7; rs1d = 32'hDEAD; rda = 7; rdw = 32'h1234;
      fire(2, 32'h8, 32'hC);
      chk("raw_old", {56'd0, flags}, 64'h00);
      rs2a = 7; rs2d = 32'h1234; fire(3, 32'hC, 32'h10);
      chk("rs2_ok", {56'd0, flags}, 64'h00);
      rs2a = 7; rs2d = 32'h0; fire(4, 32'h10, 32'h14);
      chk("rs2_bad", {56'd0, flags}, 64'h10);
      chk("rs2_first", first, 64'd4);

      // x0 write and illegal mask; then x0 read nonzero
      do_reset();
      rda = 0; rdw = 5; rmask = 4'hF; wmask = 4'h1;
      fire(0, 32'h0, 32'h4);
      chk("x0_mask", {56'd0, flags}, 64'h24);
      chk("x0_first", first, 64'd0);
      chk("x0_err", {63'd0, err}, 64'd1);
      rs1a = 0; rs1d = 1; fire(1, 32'h4, 32'h8);
      chk("x0_rs1", {56'd0, flags}, 64'h2C);

      // Halt, retire after halt, async reset mid-cycle
      do_reset();
      halt = 1; fire(0, 32'h0, 32'h4);
      chk("halt_set", {63'd0, halted}, 64'd1);
      chk("halt_flags", {56'd0, flags}, 64'h00);
      fire(1, 32'h4, 32'h8);
      chk("after_halt", {56'd0, flags}, 64'h40);
      chk("after_halt_ret", retired, 64'd2);
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("arst_err", {63'd0, err}, 64'd0);
      chk("arst_flags", {56'd0, flags}, 64'd0);
      chk("arst_retired", retired, 64'd0);
      chk("arst_halted", {63'd0, halted}, 64'd0);
      chk("arst_first", first, 64'd0);
      @(negedge clk);
      rst = 0;
      fire(0, 32'h0, 32'h4);
      chk("post_rst", {56'd0, flags}, 64'h00);

      // Trapped retirement: no align flag, no shadow write
      do_reset();
      trap = 1; rda = 3; rdw = 32'h55; fire(0, 32'h0, 32'h102);
      chk("trap_flags", {56'd0, flags}, 64'h00);
      rs1a = 3; rs1d = 32'h99; fire(1, 32'h102, 32'h108);
      chk("trap_noshadow", {56'd0, flags}, 64'h00);
      fire(2, 32'h100, 32'h10E);
      chk("pc_align", {56'd0, flags}, 64'h82);
      chk("pc_first", first, 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
